// File: rtl/selection_input.sv
// selection_input: synchronizes and debounces the eight product buttons and issues
// exactly one one-hot selection pulse per clean key press to the vend state machine.
module selection_input #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] buttons,
    input  logic [1:0] state,
    output logic [2:0] product_id,
    output logic [7:0] decoder_out,
    output logic       key_error
);

    localparam logic [1:0] VEND_IDLE = 2'b00;
    localparam logic [7:0] CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_RELEASE,
        READY,
        ISSUE,
        LOCKED
    } sel_state_t;

    sel_state_t sel_state;
    sel_state_t sel_next;

    logic [7:0] btn_m;
    logic [7:0] btn_s;
    logic [7:0] stable;
    logic [7:0] cnt [8];
    logic [7:0] armed;
    logic [1:0] fill;

    logic       no_key;
    logic       one_key;
    logic       multi_key;
    logic [2:0] key_index;
    logic       do_issue;
    logic       do_error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_m <= '0;
            btn_s <= '0;
        end else begin
            btn_m <= buttons;
            btn_s <= btn_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (btn_s[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= btn_s[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    // A key is armed once it has been seen released after the sync pipe refilled,
    // so a key held through reset can never be issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill  <= '0;
            armed <= '0;
        end else if (fill != 2'd2) begin
            fill <= fill + 2'd1;
        end else begin
            armed <= armed | ~btn_s;
        end
    end

    always_comb begin
        key_index = '0;
        for (int i = 0; i < 8; i++) begin
            if (stable[i]) begin
                key_index = 3'(i);
            end
        end
    end

    assign no_key    = (stable == 8'd0);
    assign one_key   = !no_key && ((stable & (stable - 8'd1)) == 8'd0);
    assign multi_key = !no_key && !one_key;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_state <= WAIT_RELEASE;
        end else begin
            sel_state <= sel_next;
        end
    end

    always_comb begin
        sel_next = sel_state;
        do_issue = 1'b0;
        do_error = 1'b0;
        case (sel_state)
            WAIT_RELEASE: begin
                if (no_key) begin
                    sel_next = READY;
                end
            end
            READY: begin
                if (multi_key) begin
                    do_error = 1'b1;
                    sel_next = WAIT_RELEASE;
                end else if (one_key) begin
                    if (state == VEND_IDLE && (stable & armed) != 8'd0) begin
                        do_issue = 1'b1;
                        sel_next = ISSUE;
                    end else begin
                        sel_next = WAIT_RELEASE;
                    end
                end
            end
            ISSUE: begin
                sel_next = LOCKED;
            end
            LOCKED: begin
                if (state == VEND_IDLE) begin
                    sel_next = WAIT_RELEASE;
                end
            end
            default: begin
                sel_next = WAIT_RELEASE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            product_id  <= '0;
            decoder_out <= '0;
            key_error   <= 1'b0;
        end else begin
            key_error   <= do_error;
            decoder_out <= do_issue ? stable : 8'd0;
            if (do_issue) begin
                product_id <= key_index;
            end
        end
    end

endmodule

// File: tb/tb_selection_input.sv
// tb_selection_input: directed scenarios plus randomized key traffic, checked every
// cycle against a window-based behavioural model of the selection stage.
module tb_selection_input;

    localparam int D = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] buttons = 8'd0;
    logic [1:0] state   = 2'b00;
    logic [2:0] product_id;
    logic [7:0] decoder_out;
    logic       key_error;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int err_seen     = 0;
    int pulse_val[$];
    int pulse_cyc[$];

    selection_input #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .buttons    (buttons),
        .state      (state),
        .product_id (product_id),
        .decoder_out(decoder_out),
        .key_error  (key_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model state
    logic [7:0] m_b1 = 0, m_bs = 0, m_stable = 0, m_armed = 0, m_dec = 0;
    logic [2:0] m_pid = 0;
    logic       m_err = 0;
    logic [7:0] m_hist[$];
    int         m_edges = 0;
    bit         m_need_release = 1, m_issued = 0, m_wait_idle = 0;

    task automatic checkOutput(string name, int actual, int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic modelStep();
        int         n;
        logic [7:0] win_and;
        logic [7:0] win_or;
        logic [7:0] nxt;
        logic [7:0] new_dec;
        logic       new_err;
        new_dec = 8'd0;
        new_err = 1'b0;
        n = $countones(m_stable);
        if (m_issued) begin
            m_issued    = 0;
            m_wait_idle = 1;
        end else if (m_wait_idle) begin
            if (state == 2'b00) begin
                m_wait_idle    = 0;
                m_need_release = 1;
            end
        end else if (m_need_release) begin
            if (n == 0) m_need_release = 0;
        end else if (n > 1) begin
            new_err        = 1'b1;
            m_need_release = 1;
        end else if (n == 1) begin
            if (state == 2'b00 && (m_stable & m_armed) != 8'd0) begin
                new_dec = m_stable;
                for (int k = 0; k < 8; k++) begin
                    if (m_stable == (8'd1 << k)) m_pid = 3'(k);
                end
                m_issued = 1;
            end else begin
                m_need_release = 1;
            end
        end
        if (m_edges >= 2) m_armed = m_armed | ~m_bs;
        // A key flips only when the last D synchronized samples all disagree with it
        m_hist.push_back(m_bs);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        nxt = m_stable;
        if (m_hist.size() == D) begin
            win_and = 8'hFF;
            win_or  = 8'h00;
            foreach (m_hist[j]) begin
                win_and = win_and & m_hist[j];
                win_or  = win_or | m_hist[j];
            end
            nxt = (m_stable | win_and) & ~(~win_or & m_stable);
        end
        m_stable = nxt;
        m_dec    = new_dec;
        m_err    = new_err;
        m_bs     = m_b1;
        m_b1     = buttons;
        if (m_edges < 2) m_edges++;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_b1 = 0; m_bs = 0; m_stable = 0; m_armed = 0; m_dec = 0;
            m_pid = 0; m_err = 0; m_edges = 0;
            m_hist.delete();
            m_need_release = 1; m_issued = 0; m_wait_idle = 0;
        end else begin
            modelStep();
        end
    end

    always @(negedge clk) begin
        checkOutput("decoder_out", decoder_out, m_dec);
        checkOutput("key_error", key_error, m_err);
        checkOutput("product_id", product_id, m_pid);
        if (decoder_out != 8'd0) begin
            pulse_val.push_back(decoder_out);
            pulse_cyc.push_back(cyc);
        end
        if (key_error) err_seen++;
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(logic [7:0] b, logic [1:0] s, int n);
        buttons = b;
        state   = s;
        step(n);
    endtask

    task automatic clearLog();
        pulse_val.delete();
        pulse_cyc.delete();
        err_seen = 0;
    endtask

    function automatic int pulseAt(int idx);
        return (pulse_val.size() > idx) ? pulse_val[idx] : -1;
    endfunction

    function automatic int cycAt(int idx);
        return (pulse_cyc.size() > idx) ? pulse_cyc[idx] : -1;
    endfunction

    initial begin
        int c;
        int hold;
        logic [7:0] b;
        logic [1:0] s;
        #1 reset = 1'b0;
        step(3);
        checkOutput("reset_decoder_out", decoder_out, 0);
        checkOutput("reset_key_error", key_error, 0);
        checkOutput("reset_product_id", product_id, 0);

        // Reset release with no key
        clearLog();
        reset = 1'b1;
        step(10);
        checkOutput("idle_no_pulse", pulse_val.size(), 0);

        // Key 5 clean press
        clearLog();
        c = cyc;
        applyStimulus(8'h20, 2'b00, 20);
        checkOutput("key5_pulse_count", pulse_val.size(), 1);
        checkOutput("key5_value", pulseAt(0), 'h20);
        checkOutput("key5_latency", cycAt(0), c + 7);
        applyStimulus(8'h00, 2'b00, 12);
        checkOutput("key5_pid_held", product_id, 5);

        // Key 2 bouncing then held
        clearLog();
        applyStimulus(8'h04, 2'b00, 1);
        applyStimulus(8'h00, 2'b00, 1);
        applyStimulus(8'h04, 2'b00, 1);
        applyStimulus(8'h04, 2'b00, 1);
        applyStimulus(8'h00, 2'b00, 1);
        c = cyc;
        applyStimulus(8'h04, 2'b00, 15);
        checkOutput("bounce_pulse_count", pulse_val.size(), 1);
        checkOutput("bounce_value", pulseAt(0), 'h04);
        checkOutput("bounce_latency", cycAt(0), c + 7);
        applyStimulus(8'h00, 2'b00, 12);

        // Keys 1 and 3 together, then key 3 alone
        clearLog();
        applyStimulus(8'h0A, 2'b00, 15);
        checkOutput("multi_err_count", err_seen, 1);
        checkOutput("multi_no_pulse", pulse_val.size(), 0);
        applyStimulus(8'h00, 2'b00, 12);
        applyStimulus(8'h08, 2'b00, 15);
        checkOutput("key3_pulse_count", pulse_val.size(), 1);
        checkOutput("key3_value", pulseAt(0), 'h08);
        applyStimulus(8'h00, 2'b00, 12);

        // Key 7 while PAYMENT
        clearLog();
        applyStimulus(8'h80, 2'b10, 15);
        checkOutput("busy_no_pulse", pulse_val.size(), 0);
        checkOutput("busy_pid_kept", product_id, 3);
        applyStimulus(8'h00, 2'b10, 4);
        applyStimulus(8'h00, 2'b00, 12);

        // Key 0 held through a full vend cycle
        clearLog();
        applyStimulus(8'h01, 2'b00, 8);
        applyStimulus(8'h01, 2'b01, 3);
        applyStimulus(8'h01, 2'b10, 3);
        applyStimulus(8'h01, 2'b11, 3);
        applyStimulus(8'h01, 2'b00, 10);
        checkOutput("held_single_pulse", pulse_val.size(), 1);
        applyStimulus(8'h00, 2'b00, 12);
        applyStimulus(8'h01, 2'b00, 15);
        checkOutput("repress_pulse_count", pulse_val.size(), 2);
        checkOutput("repress_value", pulseAt(1), 'h01);
        applyStimulus(8'h00, 2'b00, 12);

        // Reset with key 4 held
        clearLog();
        applyStimulus(8'h10, 2'b00, 3);
        reset = 1'b0;
        step(3);
        reset = 1'b1;
        applyStimulus(8'h10, 2'b00, 20);
        checkOutput("held_reset_no_pulse", pulse_val.size(), 0);
        applyStimulus(8'h00, 2'b00, 12);
        applyStimulus(8'h10, 2'b00, 15);
        checkOutput("after_reset_pulse", pulseAt(0), 'h10);
        applyStimulus(8'h00, 2'b00, 12);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4:  b = 8'h00;
                5, 6, 7:        b = (8'd1 << $urandom_range(0, 7)) | (8'd1 << $urandom_range(0, 7));
                default:        b = 8'd1 << $urandom_range(0, 7);
            endcase
            s = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hold = $urandom_range(1, 10);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                step(2);
                reset = 1'b1;
            end
            applyStimulus(b, s, hold);
        end
        applyStimulus(8'h00, 2'b00, 12);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
